arith_mult_arb: RTL and testbench

Round-robin arbiter that shares one pipelined `arith_mult_core` between `NB_REQ` independent requesters. Each cycle it grants at most one valid request and registers the operands into the multiplier. It carries the requester index alongside the multiplier pipeline and returns each product to its originator with a one-hot valid. It sits between request-generating datapath units (modular reduction, NTT butterflies, key-switch accumulators) and a single DSP-based multiplier, so that low-duty-cycle users do not each instantiate their own.

---
 rtl/arith_mult_arb_pkg.sv | 26 ++
 rtl/arith_mult_core_pkg.sv | 11 +
 rtl/arith_mult_arb_rr.sv | 45 ++++
 rtl/arith_mult_core.sv | 34 +++
 rtl/arith_mult_arb.sv | 146 ++++++++++++++
 tb/tb_arith_mult_arb.sv | 270 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/arith_mult_arb_pkg.sv
// Types and latency helper for the shared-multiplier arbiter.
// Optional feature macro: ARITH_MULT_ARB_OUT_REG_EN (adds an output register stage).
package arith_mult_arb_pkg;

  // Widest requester index the tracking pipe can carry. The instantiating
  // module must keep $clog2(NB_REQ) at or below this; the id field is
  // zero-extended on entry and sliced back to REQ_W at the tail.
  localparam int unsigned TRK_ID_W = 8;

  // One entry of the {vld, id} tracking pipe that runs beside the core.
  typedef struct packed {
    logic                vld;
    logic [TRK_ID_W-1:0] id;
  } trk_entry_t;

  // Cycles from the transfer edge to the product on the outputs:
  // one operand register stage, the core, and the optional output register.
  function automatic int unsigned get_latency();
`ifdef ARITH_MULT_ARB_OUT_REG_EN
    return 2 + arith_mult_core_pkg::get_latency();
`else
    return 1 + arith_mult_core_pkg::get_latency();
`endif
  endfunction

endpackage

// File: rtl/arith_mult_core_pkg.sv
// Shared constants for the pipelined unsigned multiplier core.
package arith_mult_core_pkg;

  // Register stages between the core's operand inputs and its product output.
  localparam int unsigned CORE_LATENCY = 6;

  function automatic int unsigned get_latency();
    return CORE_LATENCY;
  endfunction

endpackage

// File: rtl/arith_mult_arb_rr.sv
// Round-robin picker for the shared multiplier: combinational one-hot grant
// plus the pointer register remembering the last granted requester.
module arith_mult_arb_rr
  import arith_mult_arb_pkg::*;
#(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned REQ_W  = $clog2(NB_REQ)
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic [NB_REQ-1:0] req,
  output logic [NB_REQ-1:0] gnt,
  output logic [REQ_W-1:0]  gnt_id
);

  logic [REQ_W-1:0] ptr;
  logic             found;

  // Search from ptr+1 upward with wrap; first valid request wins. No grant in reset.
  always_comb begin
    int unsigned idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NB_REQ; k++) begin
      idx = (32'(ptr) + k) % NB_REQ;
      if (s_rst_n && !found && req[REQ_W'(idx)]) begin
        found                = 1'b1;
        gnt[REQ_W'(idx)]     = 1'b1;
        gnt_id               = REQ_W'(idx);
      end
    end
  end

  // Pointer moves to the winner only when something is granted; reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      ptr <= REQ_W'(NB_REQ - 1);
    end else if (found) begin
      ptr <= gnt_id;
    end
  end

endmodule

// File: rtl/arith_mult_core.sv
// Pipelined unsigned OP_W x OP_W multiplier with a fixed, non-stalling latency.
// The product is formed at the first stage and then carried through the rest,
// giving the DSP tools registers to absorb into the multiplier block.
module arith_mult_core
  import arith_mult_core_pkg::*;
#(
  parameter int unsigned OP_W    = 32,
  parameter int unsigned LATENCY = arith_mult_core_pkg::get_latency()
) (
  input  logic              clk,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [2*OP_W-1:0] z
);

  logic [2*OP_W-1:0] stage [LATENCY];
  logic [2*OP_W-1:0] prod;

  // Full-width unsigned product of the current operands.
  always_comb begin
    prod = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
  end

  // Data-only shift pipe; no reset so it maps cleanly onto DSP/SRL resources.
  always_ff @(posedge clk) begin
    stage[0] <= prod;
    for (int k = 1; k < int'(LATENCY); k++) begin
      stage[k] <= stage[k-1];
    end
  end

  assign z = stage[LATENCY-1];

endmodule

// File: rtl/arith_mult_arb.sv
// Shares one pipelined multiplier between NB_REQ requesters. A round-robin
// picker grants at most one request per cycle; the granted operands are
// registered (S0) into the core, and a {vld, id} pipe tracks each product so
// it is returned to its originator with a one-hot valid.
// Optional feature macro: ARITH_MULT_ARB_OUT_REG_EN re-registers out_z,
// out_id and out_vld (one extra cycle, out_z resets to 0).
module arith_mult_arb
  import arith_mult_arb_pkg::*;
#(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned OP_W   = 32,
  parameter int unsigned REQ_W  = $clog2(NB_REQ)
) (
  input  logic                   clk,
  input  logic                   s_rst_n,
  input  logic [NB_REQ*OP_W-1:0] in_a,
  input  logic [NB_REQ*OP_W-1:0] in_b,
  input  logic [NB_REQ-1:0]      in_vld,
  output logic [NB_REQ-1:0]      in_rdy,
  output logic [2*OP_W-1:0]      out_z,
  output logic [REQ_W-1:0]       out_id,
  output logic [NB_REQ-1:0]      out_vld,
  output logic                   busy
);

  localparam int unsigned CORE_LAT = arith_mult_core_pkg::get_latency();

  logic [NB_REQ-1:0] gnt;
  logic [REQ_W-1:0]  gnt_id;
  logic [OP_W-1:0]   a_arr [NB_REQ];
  logic [OP_W-1:0]   b_arr [NB_REQ];

  logic              s0_vld;
  logic [REQ_W-1:0]  s0_id;
  logic [OP_W-1:0]   s0_a;
  logic [OP_W-1:0]   s0_b;

  trk_entry_t        trk [CORE_LAT];
  logic              vld_last;
  logic [REQ_W-1:0]  id_last;
  logic [NB_REQ-1:0] vld_oh;
  logic [2*OP_W-1:0] core_z;

  arith_mult_arb_rr #(
    .NB_REQ (NB_REQ),
    .REQ_W  (REQ_W)
  ) u_rr (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .req     (in_vld),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign in_rdy = gnt;

  // Unpack the flat operand buses so the granted slice is a plain array read.
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = in_a[gi*OP_W +: OP_W];
    assign b_arr[gi] = in_b[gi*OP_W +: OP_W];
  end

  // S0 control: valid follows the grant every cycle; id is kept between grants.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      s0_vld <= 1'b0;
      s0_id  <= '0;
    end else begin
      s0_vld <= |gnt;
      if (|gnt) begin
        s0_id <= gnt_id;
      end
    end
  end

  // S0 operands: loaded only on a grant to avoid toggling the core when idle.
  always_ff @(posedge clk) begin
    if (|gnt) begin
      s0_a <= a_arr[gnt_id];
      s0_b <= b_arr[gnt_id];
    end
  end

  arith_mult_core #(
    .OP_W    (OP_W),
    .LATENCY (CORE_LAT)
  ) u_core (
    .clk (clk),
    .a   (s0_a),
    .b   (s0_b),
    .z   (core_z)
  );

  // Tracking pipe mirrors the core depth; reset drops every in-flight product.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      for (int k = 0; k < int'(CORE_LAT); k++) begin
        trk[k] <= '0;
      end
    end else begin
      trk[0] <= '{vld: s0_vld, id: TRK_ID_W'(s0_id)};
      for (int k = 1; k < int'(CORE_LAT); k++) begin
        trk[k] <= trk[k-1];
      end
    end
  end

  assign vld_last = trk[CORE_LAT-1].vld;
  assign id_last  = trk[CORE_LAT-1].id[REQ_W-1:0];

  // Decode the tail id into a one-hot valid, gated by the tail valid.
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_onehot
    assign vld_oh[gi] = vld_last && (id_last == REQ_W'(gi));
  end

  // busy covers the operand stage and every tracked stage of the core.
  always_comb begin
    busy = s0_vld;
    for (int k = 0; k < int'(CORE_LAT); k++) begin
      busy = busy | trk[k].vld;
    end
  end

`ifdef ARITH_MULT_ARB_OUT_REG_EN
  // Output register; payload loads only with a result, so out_z stays 0 until the first product.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      out_z   <= '0;
      out_id  <= '0;
      out_vld <= '0;
    end else begin
      out_vld <= vld_oh;
      if (vld_last) begin
        out_z  <= core_z;
        out_id <= id_last;
      end
    end
  end
`else
  // Outputs straight from the core and the tracking-pipe tail; out_z is qualified by out_vld only.
  assign out_z   = core_z;
  assign out_id  = id_last;
  assign out_vld = vld_oh;
`endif

endmodule

// File: tb/tb_arith_mult_arb.sv
// Directed self-checking bench for arith_mult_arb (NB_REQ=4, OP_W=32).
// Honours ARITH_MULT_ARB_OUT_REG_EN: expected latency becomes 8 instead of 7.
`timescale 1ns/1ps
module tb_arith_mult_arb;

  localparam int NB_REQ = 4;
  localparam int OP_W   = 32;
  localparam int REQ_W  = 2;
`ifdef ARITH_MULT_ARB_OUT_REG_EN
  localparam int LAT    = 8;
`else
  localparam int LAT    = 7;
`endif

  logic                   clk;
  logic                   s_rst_n;
  logic [NB_REQ*OP_W-1:0] in_a;
  logic [NB_REQ*OP_W-1:0] in_b;
  logic [NB_REQ-1:0]      in_vld;
  logic [NB_REQ-1:0]      in_rdy;
  logic [2*OP_W-1:0]      out_z;
  logic [REQ_W-1:0]       out_id;
  logic [NB_REQ-1:0]      out_vld;
  logic                   busy;

  int total;
  int bad;

  arith_mult_arb #(
    .NB_REQ (NB_REQ),
    .OP_W   (OP_W)
  ) dut (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .out_z   (out_z),
    .out_id  (out_id),
    .out_vld (out_vld),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    in_a[i*OP_W +: OP_W] = a;
    in_b[i*OP_W +: OP_W] = b;
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    s_rst_n = 1'b0;
    in_vld  = '0;
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0;
    in_vld  = 4'hF;
    for (int i = 0; i < NB_REQ; i++) set_op(i, 32'(i + 1), 32'd7);
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_rdy !== 4'b0000) begin bad++; $display("FAIL reset_in_rdy: got %b expected %b", in_rdy, 4'b0000); end
    total++; if (out_vld !== 4'b0000) begin bad++; $display("FAIL reset_out_vld: got %b expected %b", out_vld, 4'b0000); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (out_id !== 2'd0) begin bad++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
`ifdef ARITH_MULT_ARB_OUT_REG_EN
    total++; if (out_z !== 64'd0) begin bad++; $display("FAIL reset_out_z: got %h expected 0", out_z); end
`endif
    s_rst_n = 1'b1;
    #1;
    total++; if (in_rdy !== 4'b0001) begin bad++; $display("FAIL first_grant: got %b expected %b", in_rdy, 4'b0001); end
    step();
    in_vld = '0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_grant: got %b expected 1", busy); end
    $display("reset: done");
  endtask

  task automatic test_single();
    logic [3:0] exp_vld;
    logic       exp_busy;
    apply_reset();
    set_op(1, 32'h0000_0003, 32'h0000_0005);
    in_vld = 4'b0010;
    #1;
    total++; if (in_rdy !== 4'b0010) begin bad++; $display("FAIL single_rdy: got %b expected %b", in_rdy, 4'b0010); end
    step();
    in_vld = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      exp_vld  = (k == LAT) ? 4'b0010 : 4'b0000;
      exp_busy = (k <= 7);
      total++; if (out_vld !== exp_vld) begin bad++; $display("FAIL single_out_vld t+%0d: got %b expected %b", k, out_vld, exp_vld); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL single_busy t+%0d: got %b expected %b", k, busy, exp_busy); end
      if (k == LAT) begin
        total++; if (out_z !== 64'd15) begin bad++; $display("FAIL single_out_z: got %h expected %h", out_z, 64'd15); end
        total++; if (out_id !== 2'd1) begin bad++; $display("FAIL single_out_id: got %0d expected 1", out_id); end
        $display("single: req1 3*5 -> %0d at t+%0d", out_z, k);
      end
`ifdef ARITH_MULT_ARB_OUT_REG_EN
      if (k < LAT) begin
        total++; if (out_z !== 64'd0) begin bad++; $display("FAIL single_out_z_pre t+%0d: got %h expected 0", k, out_z); end
      end
`endif
      step();
    end
  endtask

  task automatic test_all_rr();
    logic [63:0] exp_z [4];
    logic [3:0]  exp_vld;
    logic [3:0]  exp_rdy;
    exp_z[0] = 64'd32;
    exp_z[1] = 64'd51;
    exp_z[2] = 64'd72;
    exp_z[3] = 64'd95;
    apply_reset();
    for (int i = 0; i < NB_REQ; i++) set_op(i, 32'(i + 2), 32'(i + 16));
    for (int n = 0; n < 12 + LAT + 1; n++) begin
      int g;
      g = n - LAT;
      exp_vld = (g >= 0 && g < 12) ? (4'b0001 << (g % 4)) : 4'b0000;
      total++; if (out_vld !== exp_vld) begin bad++; $display("FAIL rr_out_vld n=%0d: got %b expected %b", n, out_vld, exp_vld); end
      if (g >= 0 && g < 12) begin
        total++; if (out_z !== exp_z[g % 4]) begin bad++; $display("FAIL rr_out_z n=%0d: got %h expected %h", n, out_z, exp_z[g % 4]); end
        total++; if (out_id !== 2'(g % 4)) begin bad++; $display("FAIL rr_out_id n=%0d: got %0d expected %0d", n, out_id, g % 4); end
      end
      in_vld = (n < 12) ? 4'hF : 4'h0;
      #1;
      exp_rdy = (n < 12) ? (4'b0001 << (n % 4)) : 4'b0000;
      total++; if (in_rdy !== exp_rdy) begin bad++; $display("FAIL rr_grant n=%0d: got %b expected %b", n, in_rdy, exp_rdy); end
      if (n < 12) $display("rr: cycle %0d grant %b", n, in_rdy);
      step();
    end
  endtask

  task automatic test_wrap();
    logic [1:0]  exp_id [3];
    logic [63:0] exp_z  [3];
    logic [3:0]  exp_vld;
    exp_id[0] = 2'd3; exp_z[0] = 64'd40;
    exp_id[1] = 2'd0; exp_z[1] = 64'd10;
    exp_id[2] = 2'd2; exp_z[2] = 64'd30;
    apply_reset();
    for (int i = 0; i < NB_REQ; i++) set_op(i, 32'(i + 1), 32'd10);
    in_vld = 4'b1000;
    #1;
    total++; if (in_rdy !== 4'b1000) begin bad++; $display("FAIL wrap_grant3: got %b expected %b", in_rdy, 4'b1000); end
    step();
    in_vld = 4'b0101;
    #1;
    total++; if (in_rdy !== 4'b0001) begin bad++; $display("FAIL wrap_grant0: got %b expected %b", in_rdy, 4'b0001); end
    step();
    #1;
    total++; if (in_rdy !== 4'b0100) begin bad++; $display("FAIL wrap_grant2: got %b expected %b", in_rdy, 4'b0100); end
    step();
    in_vld = '0;
    repeat (LAT - 3) step();
    for (int j = 0; j < 3; j++) begin
      exp_vld = 4'b0001 << exp_id[j];
      total++; if (out_vld !== exp_vld) begin bad++; $display("FAIL wrap_out_vld %0d: got %b expected %b", j, out_vld, exp_vld); end
      total++; if (out_id !== exp_id[j]) begin bad++; $display("FAIL wrap_out_id %0d: got %0d expected %0d", j, out_id, exp_id[j]); end
      total++; if (out_z !== exp_z[j]) begin bad++; $display("FAIL wrap_out_z %0d: got %h expected %h", j, out_z, exp_z[j]); end
      $display("wrap: result %0d id=%0d z=%0d", j, out_id, out_z);
      step();
    end
  endtask

  task automatic test_max();
    apply_reset();
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    in_vld = 4'b0100;
    #1;
    total++; if (in_rdy !== 4'b0100) begin bad++; $display("FAIL max_grant: got %b expected %b", in_rdy, 4'b0100); end
    step();
    in_vld = '0;
    repeat (LAT - 1) step();
    total++; if (out_vld !== 4'b0100) begin bad++; $display("FAIL max_out_vld: got %b expected %b", out_vld, 4'b0100); end
    total++; if (out_z !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL max_out_z: got %h expected %h", out_z, 64'hFFFF_FFFE_0000_0001); end
    total++; if (out_id !== 2'd2) begin bad++; $display("FAIL max_out_id: got %0d expected 2", out_id); end
    $display("max: z=%h", out_z);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ez;
    logic [3:0]  exp_rdy;
    apply_reset();
    for (int n = 0; n < 10 + LAT + 1; n++) begin
      int g;
      g = n - LAT;
      if (g >= 0 && g < 10) begin
        ez = 64'((g + 1) * 3);
        total++; if (out_vld !== 4'b0010) begin bad++; $display("FAIL b2b_out_vld n=%0d: got %b expected %b", n, out_vld, 4'b0010); end
        total++; if (out_z !== ez) begin bad++; $display("FAIL b2b_out_z n=%0d: got %h expected %h", n, out_z, ez); end
        total++; if (out_id !== 2'd1) begin bad++; $display("FAIL b2b_out_id n=%0d: got %0d expected 1", n, out_id); end
      end else begin
        total++; if (out_vld !== 4'b0000) begin bad++; $display("FAIL b2b_idle_vld n=%0d: got %b expected %b", n, out_vld, 4'b0000); end
      end
      if (n < 10) begin
        set_op(1, 32'(n + 1), 32'd3);
        in_vld = 4'b0010;
      end else begin
        in_vld = '0;
      end
      #1;
      exp_rdy = (n < 10) ? 4'b0010 : 4'b0000;
      total++; if (in_rdy !== exp_rdy) begin bad++; $display("FAIL b2b_grant n=%0d: got %b expected %b", n, in_rdy, exp_rdy); end
      step();
    end
    $display("b2b: done");
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_rdy;
    apply_reset();
    for (int i = 0; i < NB_REQ; i++) set_op(i, 32'(i + 1), 32'd2);
    for (int n = 0; n < 3; n++) begin
      in_vld = 4'b0111;
      #1;
      exp_rdy = 4'b0001 << n;
      total++; if (in_rdy !== exp_rdy) begin bad++; $display("FAIL mid_grant n=%0d: got %b expected %b", n, in_rdy, exp_rdy); end
      step();
    end
    in_vld = '0;
    step();
    step();
    s_rst_n = 1'b0;
    step();
    s_rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
    for (int n = 6; n <= 12; n++) begin
      total++; if (out_vld !== 4'b0000) begin bad++; $display("FAIL mid_out_vld n=%0d: got %b expected %b", n, out_vld, 4'b0000); end
      step();
    end
    in_vld = 4'hF;
    #1;
    total++; if (in_rdy !== 4'b0001) begin bad++; $display("FAIL mid_next_grant: got %b expected %b", in_rdy, 4'b0001); end
    in_vld = '0;
    step();
    $display("reset_mid: done");
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    s_rst_n = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_vld  = '0;
    test_reset();
    test_single();
    test_all_rr();
    test_wrap();
    test_max();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
